// File: rtl/reset_ce_sequencer.sv
`default_nettype none
// ============================================================================
// reset_ce_sequencer
// Holds NUM_STAGES banks in reset, then releases them in index order.
// Revision: 1.0
// ============================================================================
module reset_ce_sequencer #(
   parameter int NUM_STAGES  = 4,
   parameter int HOLD_CYCLES = 16,
   parameter int STEP_CYCLES = 8
) (
   input  logic                  clk,
   input  logic                  i_sr_n,
   input  logic                  i_req,
   input  logic                  i_halt,
   output logic [NUM_STAGES-1:0] o_sr_out,
   output logic [NUM_STAGES-1:0] o_ce_out,
   output logic                  o_done,
   output logic                  o_busy
);

   localparam int c_MAX_CNT = (HOLD_CYCLES > STEP_CYCLES) ? HOLD_CYCLES : STEP_CYCLES;
   localparam int c_CW      = $clog2(c_MAX_CNT + 1);
   localparam int c_IW      = $clog2(NUM_STAGES) + 1;

   localparam logic [c_CW-1:0] c_HOLD_LOAD = c_CW'(HOLD_CYCLES - 1);
   localparam logic [c_CW-1:0] c_STEP_LOAD = c_CW'(STEP_CYCLES - 1);
   localparam logic [c_IW-1:0] c_LAST_IDX  = c_IW'(NUM_STAGES - 1);

   typedef enum logic [1:0] {
      ST_ASSERT  = 2'd0,
      ST_RELEASE = 2'd1,
      ST_RUN     = 2'd2
   } state_t;

   state_t                r_state;
   logic [c_CW-1:0]       r_cnt;
   logic [c_IW-1:0]       r_idx;
   logic [NUM_STAGES-1:0] r_sr;
   logic [NUM_STAGES-1:0] r_ce;
   logic                  r_done;

   state_t                w_nxt_state;
   logic [c_CW-1:0]       w_nxt_cnt;
   logic [c_IW-1:0]       w_nxt_idx;
   logic [NUM_STAGES-1:0] w_nxt_sr;
   logic [NUM_STAGES-1:0] w_nxt_ce;
   logic                  w_nxt_done;
   logic [NUM_STAGES-1:0] w_sel;

   // One-hot of the stage due for release; the index is 0 throughout ASSERT.
   always_comb begin
      w_sel = '0;
      for (int i = 0; i < NUM_STAGES; i++) begin
         if (r_idx == c_IW'(i)) begin
            w_sel[i] = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!i_sr_n) begin
         r_state <= ST_ASSERT;
         r_cnt   <= c_HOLD_LOAD;
         r_idx   <= '0;
         r_sr    <= '1;
         r_ce    <= '0;
         r_done  <= 1'b0;
      end else begin
         r_state <= w_nxt_state;
         r_cnt   <= w_nxt_cnt;
         r_idx   <= w_nxt_idx;
         r_sr    <= w_nxt_sr;
         r_ce    <= w_nxt_ce;
         r_done  <= w_nxt_done;
      end
   end

   always_comb begin
      w_nxt_state = r_state;
      w_nxt_cnt   = r_cnt;
      w_nxt_idx   = r_idx;
      w_nxt_sr    = r_sr;
      // Enable follows the registered reset, so it lags release by one cycle.
      w_nxt_ce    = ~r_sr & {NUM_STAGES{~i_halt}};
      w_nxt_done  = (r_state == ST_RUN);

      if (i_req) begin
         w_nxt_state = ST_ASSERT;
         w_nxt_cnt   = c_HOLD_LOAD;
         w_nxt_idx   = '0;
         w_nxt_sr    = '1;
         w_nxt_ce    = '0;
         w_nxt_done  = 1'b0;
      end else begin
         case (r_state)
            ST_ASSERT: begin
               if (r_cnt == '0) begin
                  w_nxt_sr  = r_sr & ~w_sel;
                  w_nxt_cnt = c_STEP_LOAD;
                  w_nxt_idx = c_IW'(1);
                  if (NUM_STAGES == 1) begin
                     w_nxt_state = ST_RUN;
                  end else begin
                     w_nxt_state = ST_RELEASE;
                  end
               end else begin
                  w_nxt_cnt = r_cnt - c_CW'(1);
               end
            end
            ST_RELEASE: begin
               if (r_cnt == '0) begin
                  w_nxt_sr  = r_sr & ~w_sel;
                  w_nxt_cnt = c_STEP_LOAD;
                  if (r_idx == c_LAST_IDX) begin
                     w_nxt_state = ST_RUN;
                  end else begin
                     w_nxt_idx = r_idx + c_IW'(1);
                  end
               end else begin
                  w_nxt_cnt = r_cnt - c_CW'(1);
               end
            end
            ST_RUN: begin
               w_nxt_state = ST_RUN;
            end
            default: begin
               w_nxt_state = ST_ASSERT;
               w_nxt_cnt   = c_HOLD_LOAD;
               w_nxt_idx   = '0;
               w_nxt_sr    = '1;
               w_nxt_ce    = '0;
            end
         endcase
      end
   end

   assign o_sr_out = r_sr;
   assign o_ce_out = r_ce;
   assign o_done   = r_done;
   assign o_busy   = ~r_done;

endmodule
`default_nettype wire

// File: doc/reset_ce_sequencer.md
# reset_ce_sequencer

Synchronous controller that sequences the SR (synchronous reset) and CE (clock enable) inputs of NUM_STAGES downstream flip-flop banks. It holds every bank in reset for a minimum time, then releases the banks one at a time in index order at a fixed spacing, enabling each bank one cycle after its reset is released. It sits between the board-level reset and the register banks of a pipeline, so that stage 0 always comes out of reset before stage 1, and so on. A software or logic request (REQ) re-runs the whole sequence at any time.

## Interface
- NUM_STAGES, 4: number of sequenced banks; legal range 1..32.
- HOLD_CYCLES, 16: cycles all SR_OUT stay asserted after reset or REQ; must be ≥1.
- STEP_CYCLES, 8: cycles between consecutive stage releases; must be ≥1.

- CK  in  1  clock; single clock domain, all logic on rising edge.
- SR_N  in  1  reset; synchronous, active-low.
- REQ  in  1  re-sequence request, sampled each edge; level-sensitive.
- HALT  in  1  when high, forces CE_OUT of every released stage low; does not stall sequencing.
- SR_OUT  out  NUM_STAGES  per-stage synchronous reset, active-high, registered.
- CE_OUT  out  NUM_STAGES  per-stage clock enable, registered.
- DONE  out  1  all stages released and enabled, registered.
- BUSY  out  1  sequence in progress; always equals ~DONE.

## Operation
- States: ASSERT, RELEASE, RUN. A single down-counter, sized clog2(max(HOLD_CYCLES, STEP_CYCLES)+1) bits, and a stage index, sized clog2(NUM_STAGES)+1 bits.
- Reset (SR_N=0 at an edge): state=ASSERT, counter=HOLD_CYCLES-1, index=0, SR_OUT=all ones, CE_OUT=0, DONE=0, BUSY=1.
- ASSERT: all SR_OUT=1, all CE_OUT=0.
  - The counter decrements each cycle.
  - At counter 0, clear SR_OUT[0], load counter=STEP_CYCLES-1, set index=1, and go to RELEASE. If NUM_STAGES=1, go to RUN instead.
- RELEASE: the counter decrements each cycle.
  - At counter 0, clear SR_OUT[index], reload the counter, and increment index.
  - When the last stage is cleared, go to RUN.
- CE_OUT[i] rises one cycle after SR_OUT[i] falls. It is then held at ~HALT (registered).
- RUN: DONE=1, BUSY=0, SR_OUT=0, CE_OUT=all ~HALT.
- REQ=1 in any state (including ASSERT):
  - Next state is ASSERT with the counter reloaded to HOLD_CYCLES-1 and index=0.
  - Next edge: SR_OUT=all ones, CE_OUT=0, DONE=0.
  - Held REQ keeps the block in ASSERT. The hold period counts from the first edge with REQ=0.
- SR_N has priority over REQ. REQ has priority over counter expiry.
- HALT affects CE_OUT only. SR_OUT, DONE, state and counters are unaffected.

## Timing
- Edge 0 is the first edge with SR_N=1 (and REQ=0).
- SR_OUT[i] goes low after edge HOLD_CYCLES-1 + i·STEP_CYCLES, i.e. it is first seen low in cycle HOLD_CYCLES + i·STEP_CYCLES.
- CE_OUT[i] is first seen high one cycle later than SR_OUT[i] low, if HALT=0.
- DONE is first seen high in the same cycle as CE_OUT[NUM_STAGES-1] high.
- HALT to CE_OUT latency: 1 cycle, both assert and deassert.
- REQ to SR_OUT all-ones latency: 1 cycle. REQ to CE_OUT all-zero latency: 1 cycle.
- The downstream bank therefore sees SR and CE never asserted together.
- Outputs are glitch-free registered values. There is no combinational path from any input to any output.

## Test plan
Defaults: NUM_STAGES=4, HOLD_CYCLES=16, STEP_CYCLES=8.
- Power-up: hold SR_N=0 for 5 cycles, then release with HALT=0.
  - During reset: SR_OUT=4'b1111, CE_OUT=0, DONE=0, BUSY=1.
  - After release: SR_OUT low in cycles 16/24/32/40 for stages 0/1/2/3, and CE_OUT high in cycles 17/25/33/41.
  - DONE=1 from cycle 41.
- REQ mid-RELEASE: pulse REQ one cycle at cycle 28 (stages 0-1 released).
  - Next cycle: SR_OUT=4'b1111, CE_OUT=0, DONE=0.
  - Stage 0 re-releases 16 cycles after the pulse edge.
- Held REQ in RUN for 10 cycles: SR_OUT stays all ones for the whole hold.
  - Stage 0 releases 16 cycles after REQ drops.
  - DONE returns 41 cycles after REQ drops.
- HALT toggles in RUN: HALT=1 at edge N gives CE_OUT=0 from cycle N+1; HALT=0 restores 4'b1111 one cycle later.
  - SR_OUT and DONE stay constant throughout.
  - HALT during RELEASE: the release schedule is unchanged.
- SR_N=0 asserted during RELEASE (cycle 30) concurrent with REQ=1: reset values appear next cycle.
  - The sequence restarts from edge 0 semantics after SR_N returns high.
- Corner parameters:
  - NUM_STAGES=1, HOLD=1, STEP=1: SR_OUT low in cycle 1, CE_OUT and DONE high in cycle 2.
  - NUM_STAGES=32: index wraps correctly and all 32 releases are spaced by STEP_CYCLES.
